// File: rtl/ram_latency_responder.sv
`timescale 1ns/1ps
// ram_latency_responder: word-addressed RAM model answering controller requests after a programmable latency
module ram_latency_responder #(
  parameter int LAT = 2,
  parameter int DEPTH_BITS = 10
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  logic [31:0] mem [0:(1<<DEPTH_BITS)-1];
  logic [7:0] cnt, eff;
  logic lat_valid, req, bad, match;
  logic [31:0] lat_addr;
  logic [1:0] lat_op;
  logic [DEPTH_BITS-1:0] idx;
  // request decode and latency match against the latched request
  always_comb begin
    req = ramREN | ramWEN;
    bad = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b0) | (ramaddr[31:DEPTH_BITS+2] != '0);
    match = lat_valid & (lat_addr == ramaddr) & (lat_op == {ramREN, ramWEN});
    eff = match ? cnt : 8'd0;
    idx = ramaddr[DEPTH_BITS+1:2];
    ramstate = (req & bad) ? ERROR : !req ? FREE : (eff == 8'(LAT)) ? ACCESS : BUSY;
    ramload = (ramstate == ACCESS && ramREN) ? mem[idx] : 32'd0;
  end
  // latency counter and request latch
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= 8'd0;
      lat_valid <= 1'b0;
      lat_addr <= 32'd0;
      lat_op <= 2'b0;
    end else if (ramstate == FREE || ramstate == ERROR) begin
      cnt <= 8'd0;
      lat_valid <= 1'b0;
    end else begin
      lat_valid <= 1'b1;
      lat_addr <= ramaddr;
      lat_op <= {ramREN, ramWEN};
      cnt <= (ramstate == ACCESS) ? 8'd0 : eff + 8'd1;
    end
  end
  // write commit at the edge closing an ACCESS cycle
  always_ff @(posedge CLK) begin
    if (nRST && ramstate == ACCESS && ramWEN) mem[idx] <= ramstore;
  end
endmodule

// File: tb/tb_ram_latency_responder.sv
`timescale 1ns/1ps
// tb_ram_latency_responder: directed checks of four responders built with latencies 2, 0, 3 and 4
module tb_ram_latency_responder;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic ren [4];
  logic wen [4];
  logic [31:0] addr [4];
  logic [31:0] store [4];
  logic [31:0] load [4];
  logic [1:0] state [4];
  int checks = 0;
  int errors = 0;
  always #5 CLK = ~CLK;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    ram_latency_responder #(.LAT(g == 0 ? 2 : g == 1 ? 0 : g == 2 ? 3 : 4), .DEPTH_BITS(10)) dut (
      .CLK(CLK), .nRST(nRST), .ramREN(ren[g]), .ramWEN(wen[g]),
      .ramaddr(addr[g]), .ramstore(store[g]), .ramload(load[g]), .ramstate(state[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int i, input logic r, input logic w, input logic [31:0] a, input logic [31:0] s,
                     input logic [1:0] est, input logic [31:0] eld, input string tag);
    ren[i] = r; wen[i] = w; addr[i] = a; store[i] = s;
    #1;
    chk({tag, "_st"}, 32'(state[i]), 32'(est));
    chk({tag, "_ld"}, load[i], eld);
    @(posedge CLK); #1;
  endtask
  task automatic txn(input int i, input logic r, input logic w, input logic [31:0] a, input logic [31:0] s,
                     input int nb, input logic [31:0] eld, input string tag);
    for (int k = 0; k < nb; k++) cyc(i, r, w, a, s, BUSY, 32'd0, {tag, "_busy"});
    cyc(i, r, w, a, s, ACCESS, r ? eld : 32'd0, {tag, "_acc"});
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      ren[i] = 1'b0; wen[i] = 1'b0; addr[i] = 32'd0; store[i] = 32'd0;
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_st", 32'(state[i]), 32'(FREE));
      chk("rst_ld", load[i], 32'd0);
    end
    @(posedge CLK); @(posedge CLK); #1;
    nRST = 1'b1;
    // LAT=2 write then read
    txn(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 2, 32'd0, "l2_wr");
    txn(0, 1'b1, 1'b0, 32'h40, 32'd0, 2, 32'hDEADBEEF, "l2_rd");
    cyc(0, 1'b0, 1'b0, 32'd0, 32'd0, FREE, 32'd0, "l2_idle");
    // LAT=0 immediate access, held read, error cases
    txn(1, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 0, 32'd0, "l0_wr");
    for (int k = 0; k < 3; k++) cyc(1, 1'b1, 1'b0, 32'h40, 32'd0, ACCESS, 32'hDEADBEEF, "l0_rd");
    txn(1, 1'b0, 1'b1, 32'h0, 32'h11, 0, 32'd0, "l0_wr0");
    cyc(1, 1'b1, 1'b1, 32'h0, 32'h99, ERROR, 32'd0, "err_rw");
    cyc(1, 1'b1, 1'b1, 32'h0, 32'h99, ERROR, 32'd0, "err_rw_hold");
    cyc(1, 1'b0, 1'b1, 32'h41, 32'h99, ERROR, 32'd0, "err_align");
    cyc(1, 1'b1, 1'b0, 32'h41, 32'h0, ERROR, 32'd0, "err_align_rd");
    cyc(1, 1'b0, 1'b1, 32'h1000, 32'h99, ERROR, 32'd0, "err_range");
    txn(1, 1'b1, 1'b0, 32'h0, 32'd0, 0, 32'h11, "err_follow");
    cyc(1, 1'b0, 1'b0, 32'd0, 32'd0, FREE, 32'd0, "l0_idle");
    // LAT=3 request switch mid-BUSY
    txn(2, 1'b0, 1'b1, 32'h104, 32'hCAFEF00D, 3, 32'd0, "l3_wr");
    cyc(2, 1'b1, 1'b0, 32'h100, 32'd0, BUSY, 32'd0, "l3_a");
    cyc(2, 1'b1, 1'b0, 32'h100, 32'd0, BUSY, 32'd0, "l3_a");
    txn(2, 1'b1, 1'b0, 32'h104, 32'd0, 3, 32'hCAFEF00D, "l3_b");
    cyc(2, 1'b0, 1'b0, 32'd0, 32'd0, FREE, 32'd0, "l3_idle");
    // LAT=4 dropped request restarts the full latency
    txn(3, 1'b0, 1'b1, 32'h80, 32'h0, 4, 32'd0, "l4_init");
    cyc(3, 1'b0, 1'b1, 32'h84, 32'hAAAA5555, BUSY, 32'd0, "l4_drop_busy");
    cyc(3, 1'b0, 1'b1, 32'h84, 32'hAAAA5555, BUSY, 32'd0, "l4_drop_busy");
    cyc(3, 1'b0, 1'b0, 32'h84, 32'hAAAA5555, FREE, 32'd0, "l4_drop");
    txn(3, 1'b0, 1'b1, 32'h84, 32'hAAAA5555, 4, 32'd0, "l4_rewr");
    txn(3, 1'b1, 1'b0, 32'h84, 32'd0, 4, 32'hAAAA5555, "l4_rd84");
    // LAT=4 write aborted by reset
    cyc(3, 1'b0, 1'b1, 32'h80, 32'h12345678, BUSY, 32'd0, "rst_busy");
    cyc(3, 1'b0, 1'b1, 32'h80, 32'h12345678, BUSY, 32'd0, "rst_busy");
    nRST = 1'b0;
    #1;
    chk("rst_mid_st", 32'(state[3]), 32'(BUSY));
    @(posedge CLK); #1;
    wen[3] = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    cyc(3, 1'b0, 1'b0, 32'd0, 32'd0, FREE, 32'd0, "rst_idle");
    txn(3, 1'b1, 1'b0, 32'h80, 32'd0, 4, 32'h0, "rst_rd80");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/ram_latency_responder.md
Name: ram_latency_responder

Overview:
- RAM-side responder for the memory-controller/RAM interface: accepts ramREN/ramWEN/ramaddr/ramstore and reports ramstate and ramload.
- Models a word-addressed RAM with a programmable access latency.
- Used in place of the physical RAM in pipeline and cache simulation, so arbitration wait behaviour can be exercised at any latency.

Parameters:
LAT, 2, wait cycles before ACCESS; legal range 0..255
DEPTH_BITS, 10, log2 of word count; depth = 2**DEPTH_BITS words

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
ramREN  input  1  read request, held until ACCESS
ramWEN  input  1  write request, held until ACCESS
ramaddr  input  32  byte address (word_t)
ramstore  input  32  write data (word_t)
ramload  output  32  read data, valid only while ramstate==ACCESS with ramREN
ramstate  output  2  ramstate_t from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR

Behaviour:
- Reset is asynchronous and active-low.
  - Clears cnt (8b), lat_valid, lat_addr and lat_op.
  - Outputs during reset: ramstate=FREE when no request, ramload=0.
  - Memory array is not reset; the bench writes before reading.
- req = ramREN | ramWEN.
- bad = (ramREN & ramWEN) | (ramaddr[1:0] != 0) | (ramaddr[31:DEPTH_BITS+2] != 0).
- match = lat_valid & (lat_addr==ramaddr) & (lat_op=={ramREN,ramWEN}).
- eff = match ? cnt : 0.
- ramstate is combinational, evaluated in priority order:
  - ERROR if req & bad
  - FREE if !req
  - ACCESS if eff==LAT
  - BUSY otherwise
- ramload:
  - mem[ramaddr[DEPTH_BITS+1:2]] when ramstate==ACCESS & ramREN.
  - 0 otherwise.
  - Combinational read, same cycle as ACCESS.
- Write commit: mem[index] <= ramstore at the rising edge ending a cycle with ramstate==ACCESS & ramWEN. ramstore is sampled at that edge.
- Sequential update each edge:
  - FREE or ERROR: lat_valid<=0, cnt<=0.
  - ACCESS: lat_valid<=1, latch addr/op, cnt<=0. A held identical request therefore starts a fresh access, so the next ACCESS comes LAT cycles later.
  - BUSY: lat_valid<=1, latch addr/op, cnt<=eff+1.
- Latency:
  - A request that is stable from cycle t sees BUSY for LAT cycles and ACCESS in cycle t+LAT.
  - LAT=0 gives ACCESS in the same cycle as the request (combinational).
- Request change mid-BUSY (different addr or op): the count restarts from 0 in that same cycle. Nothing is written for the abandoned request.
- Request dropped mid-BUSY: FREE, count cleared, no side effect.
- ERROR:
  - No read data, no write, count cleared.
  - Persists while the bad request is held.
- cnt never exceeds LAT: it returns to 0 on ACCESS, so there is no wrap.
- Reset asserted mid-BUSY: count and latch are cleared immediately; no write occurs.
- Read-after-write to the same address in consecutive accesses returns the new data.
  - The write commits at the ACCESS edge.
  - The read's ACCESS is at least 1 cycle later.
- Read and write in the same cycle is impossible: that combination is ERROR.

Test Plan:
- LAT=2, ramWEN=1, addr=0x40, store=0xDEADBEEF held:
  - write: BUSY,BUSY,ACCESS.
  - then ramREN=1, addr=0x40 -> BUSY,BUSY,ACCESS with ramload=0xDEADBEEF in the ACCESS cycle; ramload=0 in the BUSY cycles.
- LAT=0, ramREN=1, addr=0x40 -> ACCESS in the same cycle; ramload=0xDEADBEEF.
  - Held for 3 cycles -> ACCESS every cycle.
- LAT=3:
  - Read 0x100 for 2 cycles (BUSY,BUSY), then switch to 0x104 -> BUSY x3, then ACCESS.
  - No ACCESS ever reported for 0x100.
- Error cases:
  - ramREN=ramWEN=1 -> ERROR.
  - addr=0x41 -> ERROR.
  - addr=0x1000 with DEPTH_BITS=10 -> ERROR.
  - Follow-up read of 0x0 returns its prior value (no write happened).
- Write aborted by reset:
  - Write 0x80 <- 0x12345678 with LAT=4.
  - Pulse nRST low after 2 BUSY cycles, then drop the request.
  - Read 0x80 -> old data (0x0 after the initial write of 0).
- Write aborted by dropped request: mid-BUSY ramWEN=0 -> FREE next evaluation, cnt=0.
  - The re-issued write then needs the full LAT BUSY cycles before ACCESS.
